// File: rtl/coredefs_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : coredefs
//  Description : Shared RV32I decode definitions: ALU op codes, opcode
//                constants, ALU A-operand select enum and the ID/EX bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
package coredefs;

   // ALU op codes, numbered in funct3 order
   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SLL  = 3'd1;
   localparam logic [2:0] ALU_SLT  = 3'd2;
   localparam logic [2:0] ALU_SLTU = 3'd3;
   localparam logic [2:0] ALU_XOR  = 3'd4;
   localparam logic [2:0] ALU_SR   = 3'd5;
   localparam logic [2:0] ALU_OR   = 3'd6;
   localparam logic [2:0] ALU_AND  = 3'd7;

   // Major opcodes (instr[6:0])
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   typedef enum logic [1:0] {
      ASRC_RS1  = 2'd0,
      ASRC_PC   = 2'd1,
      ASRC_ZERO = 2'd2
   } asrc_e;

   // Everything EX needs from decode, excluding the valid bit
   typedef struct packed {
      logic [31:0] pc;
      logic [2:0]  aluctr;
      logic        aluext;
      asrc_e       asrc;
      logic        bsrc;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        regwr;
      logic        memrd;
      logic        memwr;
      logic [2:0]  funct3;
      logic        branch;
      logic        jal;
      logic        jalr;
      logic        illegal;
   } id_ex_t;

endpackage
`default_nettype wire

// File: rtl/id_stage_if.sv
`default_nettype none
// ============================================================================
//  Interface   : id_stage_if
//  Description : IF/ID -> ID/EX handshake bundle. slave = decode stage,
//                master = surrounding pipeline (fetch + execute side).
//  Revision    : 1.0 - initial release
// ============================================================================
interface id_stage_if;
   import coredefs::*;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_instr;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   id_ex_t      out_bundle;

   modport master (
      output in_valid, in_pc, in_instr, flush, out_ready,
      input  in_ready, out_valid, out_bundle
   );

   modport slave (
      input  in_valid, in_pc, in_instr, flush, out_ready,
      output in_ready, out_valid, out_bundle
   );

endinterface
`default_nettype wire

// File: rtl/id_stage_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_decoder
//  Description : Purely combinational RV32I instruction -> id_ex_t decode.
//                Illegal encodings keep their ALU fields but never write a
//                register, touch memory or redirect control flow.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32i_decoder
   import coredefs::*;
(
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   output id_ex_t      dec_o
);

   logic [6:0]  w_opc;
   logic [6:0]  w_f7;
   logic [2:0]  w_f3;
   logic [31:0] w_imm_i;
   logic [31:0] w_imm_s;
   logic [31:0] w_imm_b;
   logic [31:0] w_imm_u;
   logic [31:0] w_imm_j;
   logic [31:0] w_shamt;
   logic        w_writes_rd;
   logic        w_has_rs2;

   assign w_opc   = instr_i[6:0];
   assign w_f3    = instr_i[14:12];
   assign w_f7    = instr_i[31:25];
   assign w_imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
   assign w_imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
   assign w_imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
   assign w_imm_u = {instr_i[31:12], 12'b0};
   assign w_imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
   assign w_shamt = {27'b0, instr_i[24:20]};

   // Opcode-driven decode into the ID/EX bundle
   always_comb begin
      dec_o        = '0;
      dec_o.pc     = pc_i;
      dec_o.aluctr = ALU_ADD;
      dec_o.asrc   = ASRC_RS1;
      dec_o.rs1    = instr_i[19:15];
      dec_o.rd     = instr_i[11:7];
      dec_o.funct3 = w_f3;
      w_writes_rd  = 1'b0;
      w_has_rs2    = 1'b0;
      case (w_opc)
         OPC_OP: begin
            w_writes_rd   = 1'b1;
            w_has_rs2     = 1'b1;
            dec_o.aluctr  = w_f3;
            dec_o.aluext  = (w_f3 == 3'b000 || w_f3 == 3'b101) ? instr_i[30] : 1'b0;
            dec_o.illegal = !((w_f7 == 7'h00) ||
                              (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
         end
         OPC_OP_IMM: begin
            w_writes_rd  = 1'b1;
            dec_o.aluctr = w_f3;
            dec_o.bsrc   = 1'b1;
            dec_o.imm    = w_imm_i;
            if (w_f3 == 3'b001) begin
               dec_o.imm     = w_shamt;
               dec_o.illegal = (w_f7 != 7'h00);
            end else if (w_f3 == 3'b101) begin
               dec_o.imm     = w_shamt;
               dec_o.aluext  = instr_i[30];
               dec_o.illegal = !(w_f7 == 7'h00 || w_f7 == 7'h20);
            end
         end
         OPC_LUI, OPC_AUIPC: begin
            w_writes_rd = 1'b1;
            dec_o.asrc  = (w_opc == OPC_LUI) ? ASRC_ZERO : ASRC_PC;
            dec_o.bsrc  = 1'b1;
            dec_o.imm   = w_imm_u;
         end
         OPC_LOAD: begin
            w_writes_rd = 1'b1;
            dec_o.bsrc  = 1'b1;
            dec_o.imm   = w_imm_i;
            dec_o.memrd = 1'b1;
         end
         OPC_STORE: begin
            w_has_rs2   = 1'b1;
            dec_o.bsrc  = 1'b1;
            dec_o.imm   = w_imm_s;
            dec_o.memwr = 1'b1;
         end
         OPC_BRANCH: begin
            w_has_rs2    = 1'b1;
            dec_o.imm    = w_imm_b;
            dec_o.branch = 1'b1;
            case (w_f3)
               3'b000, 3'b001: dec_o.aluext  = 1'b1;   // equality via SUB and zero test
               3'b100, 3'b101: dec_o.aluctr  = ALU_SLT;
               3'b110, 3'b111: dec_o.aluctr  = ALU_SLTU;
               default:        dec_o.illegal = 1'b1;
            endcase
         end
         OPC_JAL: begin
            w_writes_rd = 1'b1;
            dec_o.asrc  = ASRC_PC;
            dec_o.bsrc  = 1'b1;
            dec_o.imm   = w_imm_j;
            dec_o.jal   = 1'b1;
         end
         OPC_JALR: begin
            w_writes_rd = 1'b1;
            dec_o.bsrc  = 1'b1;
            dec_o.imm   = w_imm_i;
            dec_o.jalr  = 1'b1;
         end
         default: dec_o.illegal = 1'b1;
      endcase
      if (w_has_rs2) begin
         dec_o.rs2 = instr_i[24:20];
      end
      // Writes to x0 are dropped here so EX/WB never has to check rd
      dec_o.regwr = w_writes_rd && (dec_o.rd != 5'd0) && !dec_o.illegal;
      if (dec_o.illegal) begin
         dec_o.memrd  = 1'b0;
         dec_o.memwr  = 1'b0;
         dec_o.branch = 1'b0;
         dec_o.jal    = 1'b0;
         dec_o.jalr   = 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage
//  Description : RV32I decode stage with a registered ID/EX slot and
//                valid/ready handshakes on both sides; flush kills all held
//                entries. Optional macro ID_STAGE_SKID_EN adds a second
//                (skid) entry so in_ready comes straight from a flop.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_stage
   import coredefs::*;
(
   input  wire        clk,
   input  wire        rst,
   id_stage_if.slave  bus
);

   id_ex_t w_dec;
   id_ex_t main_q, main_d;
   logic   valid_q, valid_d;
   logic   w_accept;

   rv32i_decoder u_dec (
      .instr_i (bus.in_instr),
      .pc_i    (bus.in_pc),
      .dec_o   (w_dec)
   );

`ifdef ID_STAGE_SKID_EN
   id_ex_t skid_q, skid_d;
   logic   skid_valid_q, skid_valid_d;
   logic   w_main_free;

   assign bus.in_ready = !skid_valid_q;
   assign w_accept     = bus.in_valid && !skid_valid_q;
   assign w_main_free  = !valid_q || bus.out_ready;

   // Skid drains into the main slot before any new entry, keeping order
   always_comb begin
      main_d       = main_q;
      valid_d      = valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (bus.flush) begin
         valid_d      = 1'b0;
         skid_valid_d = 1'b0;
      end else if (w_main_free) begin
         if (skid_valid_q) begin
            main_d       = skid_q;
            valid_d      = 1'b1;
            skid_valid_d = 1'b0;
         end else begin
            valid_d = w_accept;
            if (w_accept) begin
               main_d = w_dec;
            end
         end
      end else if (w_accept) begin
         skid_d       = w_dec;
         skid_valid_d = 1'b1;
      end
   end

   // Skid register update
   always_ff @(posedge clk) begin
      if (rst) begin
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
      end else begin
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
      end
   end
`else
   assign bus.in_ready = !valid_q || bus.out_ready;
   assign w_accept     = bus.in_valid && bus.in_ready;

   // Single slot: load on accept, empty when consumed or flushed
   always_comb begin
      main_d  = main_q;
      valid_d = valid_q;
      if (bus.flush) begin
         valid_d = 1'b0;
      end else if (w_accept) begin
         main_d  = w_dec;
         valid_d = 1'b1;
      end else if (bus.out_ready) begin
         valid_d = 1'b0;
      end
   end
`endif

   // ID/EX register update
   always_ff @(posedge clk) begin
      if (rst) begin
         main_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         main_q  <= main_d;
         valid_q <= valid_d;
      end
   end

   assign bus.out_valid  = valid_q;
   assign bus.out_bundle = main_q;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_stage
//  Description : Self-checking bench for id_stage: reference decoder plus a
//                FIFO model of the held entries, checked every cycle, plus
//                literal expectations for hand-decoded instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage;
   import coredefs::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   id_stage_if bus ();

   id_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int     n_tests = 0;
   int     n_fail  = 0;
   int     n_acc   = 0;
   int     n_snd   = 0;
   id_ex_t exp_q[$];
   logic   zero_exp = 1'b1;
   logic   started  = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
      if (v[bits-1]) return v | (32'hFFFF_FFFF << bits);
      return v;
   endfunction

   // Reference decode from the instruction-set rules
   function automatic id_ex_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
      id_ex_t      e;
      int          f3, f7;
      logic        writes, two_src;
      logic [31:0] v;
      e = '0;  e.pc = pc;  e.aluctr = ALU_ADD;  e.asrc = ASRC_RS1;
      e.rs1 = ins[19:15];  e.rd = ins[11:7];  e.funct3 = ins[14:12];
      f3 = int'(ins[14:12]);  f7 = int'(ins[31:25]);
      writes = 1'b0;  two_src = 1'b0;
      case (ins[6:0])
         7'h33: begin
            writes = 1'b1;  two_src = 1'b1;  e.aluctr = 3'(f3);
            if (f3 == 0 || f3 == 5) e.aluext = ins[30];
            e.illegal = !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
         end
         7'h13: begin
            writes = 1'b1;  e.aluctr = 3'(f3);  e.bsrc = 1'b1;
            if (f3 == 1 || f3 == 5) begin
               e.imm = 32'(ins[24:20]);
               if (f3 == 5) e.aluext = ins[30];
               e.illegal = (f3 == 1) ? (f7 != 0) : !(f7 == 0 || f7 == 32);
            end else e.imm = sext(32'(ins[31:20]), 12);
         end
         7'h37, 7'h17: begin
            writes = 1'b1;  e.bsrc = 1'b1;  e.imm = ins & 32'hFFFF_F000;
            e.asrc = (ins[6:0] == 7'h37) ? ASRC_ZERO : ASRC_PC;
         end
         7'h03: begin
            writes = 1'b1;  e.bsrc = 1'b1;  e.memrd = 1'b1;
            e.imm = sext(32'(ins[31:20]), 12);
         end
         7'h23: begin
            two_src = 1'b1;  e.bsrc = 1'b1;  e.memwr = 1'b1;
            e.imm = sext(32'(ins[31:25]) * 32 + 32'(ins[11:7]), 12);
         end
         7'h63: begin
            two_src = 1'b1;  e.branch = 1'b1;
            v = 32'(ins[31]) * 4096 + 32'(ins[7]) * 2048 + 32'(ins[30:25]) * 32 + 32'(ins[11:8]) * 2;
            e.imm = sext(v, 13);
            if (f3 == 0 || f3 == 1) e.aluext = 1'b1;
            else if (f3 == 4 || f3 == 5) e.aluctr = ALU_SLT;
            else if (f3 == 6 || f3 == 7) e.aluctr = ALU_SLTU;
            else e.illegal = 1'b1;
         end
         7'h6F: begin
            writes = 1'b1;  e.asrc = ASRC_PC;  e.bsrc = 1'b1;  e.jal = 1'b1;
            v = 32'(ins[31]) * 1048576 + 32'(ins[19:12]) * 4096 + 32'(ins[20]) * 2048 + 32'(ins[30:21]) * 2;
            e.imm = sext(v, 21);
         end
         7'h67: begin
            writes = 1'b1;  e.bsrc = 1'b1;  e.jalr = 1'b1;
            e.imm = sext(32'(ins[31:20]), 12);
         end
         default: e.illegal = 1'b1;
      endcase
      if (two_src) e.rs2 = ins[24:20];
      if (e.illegal) begin
         e.memrd = 0;  e.memwr = 0;  e.branch = 0;  e.jal = 0;  e.jalr = 0;
      end
      e.regwr = writes && (e.rd != 0) && !e.illegal;
      return e;
   endfunction

   function automatic logic [31:0] gen_instr();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 9))
         0: r[6:0] = 7'h33;  1: r[6:0] = 7'h13;  2: r[6:0] = 7'h37;
         3: r[6:0] = 7'h17;  4: r[6:0] = 7'h03;  5: r[6:0] = 7'h23;
         6: r[6:0] = 7'h63;  7: r[6:0] = 7'h6F;  8: r[6:0] = 7'h67;
         default: ;
      endcase
      case ($urandom_range(0, 3))
         0: r[31:25] = 7'h00;
         1: r[31:25] = 7'h20;
         default: ;
      endcase
      return r;
   endfunction

   // Model update and per-cycle compare
   always @(posedge clk) begin : cmp
      logic mdl_ready;
      logic acc, snd;
`ifdef ID_STAGE_SKID_EN
      mdl_ready = (exp_q.size() < 2);
`else
      mdl_ready = (exp_q.size() == 0) || (bus.out_ready === 1'b1);
`endif
      if (rst === 1'b1) started = 1'b1;
      if (started && rst === 1'b0) chk("in_ready", 128'(bus.in_ready), 128'(mdl_ready));
      acc = bus.in_valid && mdl_ready;
      snd = (exp_q.size() > 0) && bus.out_ready;
      if (rst) begin
         exp_q.delete();
         zero_exp = 1'b1;
      end else if (bus.flush) begin
         exp_q.delete();
      end else begin
         if (snd) begin
            void'(exp_q.pop_front());
            n_snd++;
         end
         if (acc) begin
            exp_q.push_back(ref_decode(bus.in_instr, bus.in_pc));
            zero_exp = 1'b0;
            n_acc++;
         end
      end
      #1;
      if (started) begin
         chk("out_valid", 128'(bus.out_valid), 128'(exp_q.size() > 0));
         if (exp_q.size() > 0) chk("bundle", 128'(bus.out_bundle), 128'(exp_q[0]));
         else if (zero_exp)    chk("reset_zero", 128'(bus.out_bundle), 128'd0);
      end
   end

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl);
      @(negedge clk);
      bus.in_valid  = v;
      bus.in_instr  = ins;
      bus.in_pc     = pc;
      bus.out_ready = ordy;
      bus.flush     = fl;
      @(posedge clk);
      #2;
   endtask

   logic [31:0] stall_ins [3];
   int          acc0, snd0, k;

   initial begin
      bus.in_valid = 1'b0;  bus.in_instr = '0;  bus.in_pc = '0;
      bus.out_ready = 1'b0; bus.flush = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
      chk("rst_bundle", 128'(bus.out_bundle), 128'd0);
      rst = 1'b0;

      // Hand-decoded instructions
      drive(1, 32'h002081B3, 32'h100, 1, 0);   // add x3,x1,x2
      chk("add_valid", 128'(bus.out_valid), 128'd1);
      chk("add_aluctr", 128'(bus.out_bundle.aluctr), 128'(ALU_ADD));
      chk("add_aluext", 128'(bus.out_bundle.aluext), 128'd0);
      chk("add_asrc", 128'(bus.out_bundle.asrc), 128'd0);
      chk("add_bsrc", 128'(bus.out_bundle.bsrc), 128'd0);
      chk("add_rd", 128'(bus.out_bundle.rd), 128'd3);
      chk("add_regwr", 128'(bus.out_bundle.regwr), 128'd1);
      drive(1, 32'h4032D293, 32'h104, 1, 0);   // srai x5,x5,3
      chk("srai_aluctr", 128'(bus.out_bundle.aluctr), 128'(ALU_SR));
      chk("srai_aluext", 128'(bus.out_bundle.aluext), 128'd1);
      chk("srai_imm", 128'(bus.out_bundle.imm), 128'd3);
      drive(1, 32'hFFF00093, 32'h108, 1, 0);   // addi x1,x0,-1
      chk("addi_aluext", 128'(bus.out_bundle.aluext), 128'd0);
      chk("addi_imm", 128'(bus.out_bundle.imm), 128'hFFFF_FFFF);
      drive(1, 32'h0020E463, 32'h10C, 1, 0);   // bltu x1,x2,+8
      chk("bltu_aluctr", 128'(bus.out_bundle.aluctr), 128'(ALU_SLTU));
      chk("bltu_branch", 128'(bus.out_bundle.branch), 128'd1);
      chk("bltu_regwr", 128'(bus.out_bundle.regwr), 128'd0);
      chk("bltu_imm", 128'(bus.out_bundle.imm), 128'd8);
      drive(1, 32'hFFFFFFFF, 32'h110, 1, 0);
      chk("ill_illegal", 128'(bus.out_bundle.illegal), 128'd1);
      chk("ill_regwr", 128'(bus.out_bundle.regwr), 128'd0);
      drive(0, 32'h0, 32'h0, 1, 0);
      drive(0, 32'h0, 32'h0, 1, 0);

      // Back-pressure: three instructions offered while EX stalls
      stall_ins[0] = 32'h00100093;  stall_ins[1] = 32'h00200113;  stall_ins[2] = 32'h00300193;
      acc0 = n_acc;  snd0 = n_snd;
      for (int c = 0; c < 3; c++) begin
         k = n_acc - acc0;
         drive(1, stall_ins[k], 32'h200 + 4 * k, 0, 0);
         chk("stall_hold", 128'(bus.out_bundle), 128'(ref_decode(stall_ins[0], 32'h200)));
      end
`ifdef ID_STAGE_SKID_EN
      chk("stall_accepts", 128'(n_acc - acc0), 128'd2);
`else
      chk("stall_accepts", 128'(n_acc - acc0), 128'd1);
`endif
      for (int c = 0; c < 20 && (n_acc - acc0) < 3; c++) begin
         k = n_acc - acc0;
         drive(1, stall_ins[k], 32'h200 + 4 * k, 1, 0);
      end
      for (int c = 0; c < 10 && (n_snd - snd0) < 3; c++) drive(0, 32'h0, 32'h0, 1, 0);
      chk("stall_sent", 128'(n_snd - snd0), 128'd3);

      // Flush wins over a simultaneous accept
      drive(1, 32'h00500293, 32'h300, 1, 0);
      @(negedge clk);
      bus.in_valid = 1'b1;  bus.in_instr = 32'h00600313;  bus.in_pc = 32'h304;  bus.flush = 1'b1;
      #1 chk("flush_in_ready", 128'(bus.in_ready), 128'd1);
      @(posedge clk);  #2;
      chk("flush_valid", 128'(bus.out_valid), 128'd0);
      drive(0, 32'h0, 32'h0, 1, 0);
      chk("flush_dropped", 128'(bus.out_valid), 128'd0);

      // Reset while holding an entry
      drive(1, 32'h00700393, 32'h400, 0, 0);
      @(negedge clk);
      bus.in_valid = 1'b0;  rst = 1'b1;
      @(posedge clk);  #2;
      chk("rst_hold_valid", 128'(bus.out_valid), 128'd0);
      chk("rst_hold_bundle", 128'(bus.out_bundle), 128'd0);
      @(negedge clk);  rst = 1'b0;

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         rst           = ($urandom_range(0, 399) == 0);
         bus.in_valid  = ($urandom_range(0, 9) < 7);
         bus.in_instr  = gen_instr();
         bus.in_pc     = $urandom & 32'hFFFF_FFFC;
         bus.out_ready = ($urandom_range(0, 9) < 6);
         bus.flush     = ($urandom_range(0, 29) == 0);
      end
      @(negedge clk);
      rst = 1'b0;  bus.in_valid = 1'b0;  bus.flush = 1'b0;  bus.out_ready = 1'b1;
      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
